// File: rtl/spram_arb.sv
// Three-way arbiter (CPU fetch, CPU data, boot loader) for the single-port code SPRAM.
// BOOT/RUN sequencing keeps the core off the memory until the loader has finished.
module spram_arb #(
    parameter int MAXWAIT = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        c_req,
    input  logic [31:0] c_adrs,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic        c_rerr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_wst,
    input  logic [31:0] d_adrs,
    input  logic [31:0] d_din,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_rerr,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [3:0]  l_wst,
    input  logic [31:0] l_adrs,
    input  logic [31:0] l_din,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic        l_rerr,
    input  logic        l_done,
    output logic [31:0] rdata,
    output logic        boot,
    output logic        mcs,
    output logic        mwe,
    output logic [3:0]  mwst,
    output logic [13:0] madrs,
    output logic [31:0] mdin,
    input  logic [31:0] mdout
);
    localparam logic [1:0] IC = 2'd0;
    localparam logic [1:0] ID = 2'd1;
    localparam logic [1:0] IL = 2'd2;
    localparam logic [3:0] WMAX = 4'(MAXWAIT);

    typedef struct packed {
        logic        we;
        logic [3:0]  wst;
        logic [31:0] adrs;
        logic [31:0] din;
    } req_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] id;
        logic       err;
    } owner_t;

    typedef enum logic {BOOT, RUN} state_t;

    state_t     state;
    owner_t     owner;
    logic [3:0] c_wait, l_wait;
    logic [2:0] gnt;
    logic [1:0] gid;
    req_t       sel;
    logic       any, err, acc, c_pro, l_pro;
    logic       unused_ok;

    assign c_pro = (state == RUN) && (c_wait == WMAX);
    assign l_pro = (l_wait == WMAX);

    // Promotion overrides the D > C > L base order; only L may touch memory in BOOT.
    always_comb begin
        gnt = '0;
        if (rstn) begin
            if (state == BOOT)       gnt[IL] = l_req;
            else if (c_req && c_pro) gnt[IC] = 1'b1;
            else if (l_req && l_pro) gnt[IL] = 1'b1;
            else if (d_req)          gnt[ID] = 1'b1;
            else if (c_req)          gnt[IC] = 1'b1;
            else if (l_req)          gnt[IL] = 1'b1;
        end
    end

    always_comb begin
        sel = '{we: l_we, wst: l_wst, adrs: l_adrs, din: l_din};
        gid = IL;
        if (gnt[ID]) begin
            sel = '{we: d_we, wst: d_wst, adrs: d_adrs, din: d_din};
            gid = ID;
        end else if (gnt[IC]) begin
            sel = '{we: 1'b0, wst: 4'h0, adrs: c_adrs, din: 32'h0};
            gid = IC;
        end
    end

    assign any = |gnt;
    assign err = |sel.adrs[31:16];
    assign acc = any && !err;

    assign c_gnt = gnt[IC];
    assign d_gnt = gnt[ID];
    assign l_gnt = gnt[IL];

    assign mcs   = acc;
    assign mwe   = acc && sel.we;
    assign mwst  = (acc && sel.we) ? sel.wst : 4'h0;
    assign madrs = acc ? sel.adrs[15:2] : 14'h0;
    assign mdin  = acc ? sel.din : 32'h0;

    // Byte offset is irrelevant to a word-wide memory.
    assign unused_ok = ^sel.adrs[1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= BOOT;
            owner  <= '0;
            c_wait <= 4'h0;
            l_wait <= 4'h0;
        end else begin
            if (state == BOOT && l_done)
                state <= RUN;
            owner <= '{vld: any, id: gid, err: err};
            if (state == RUN && c_req && !gnt[IC])
                c_wait <= (c_wait == WMAX) ? c_wait : 4'(c_wait + 4'd1);
            else
                c_wait <= 4'h0;
            if (l_req && !gnt[IL])
                l_wait <= (l_wait == WMAX) ? l_wait : 4'(l_wait + 4'd1);
            else
                l_wait <= 4'h0;
        end
    end

    assign boot     = (state == BOOT);
    assign c_rvalid = owner.vld && owner.id == IC;
    assign d_rvalid = owner.vld && owner.id == ID;
    assign l_rvalid = owner.vld && owner.id == IL;
    assign c_rerr   = c_rvalid && owner.err;
    assign d_rerr   = d_rvalid && owner.err;
    assign l_rerr   = l_rvalid && owner.err;
    assign rdata    = mdout;

endmodule

// File: tb/tb_spram_arb.sv
// Randomized bench for spram_arb: SPRAM behavioural memory plus a transaction-level
// reference (winner choice, shadow memory, expected responses).
module tb_spram_arb;
    localparam int MAXWAIT = 7;

    logic        clk, rstn;
    logic        c_req, c_gnt, c_rvalid, c_rerr;
    logic [31:0] c_adrs;
    logic        d_req, d_we, d_gnt, d_rvalid, d_rerr;
    logic [3:0]  d_wst;
    logic [31:0] d_adrs, d_din;
    logic        l_req, l_we, l_gnt, l_rvalid, l_rerr, l_done;
    logic [3:0]  l_wst;
    logic [31:0] l_adrs, l_din;
    logic [31:0] rdata, mdin, mdout;
    logic        boot, mcs, mwe;
    logic [3:0]  mwst;
    logic [13:0] madrs;

    spram_arb #(.MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .rstn(rstn),
        .c_req(c_req), .c_adrs(c_adrs), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rerr(c_rerr),
        .d_req(d_req), .d_we(d_we), .d_wst(d_wst), .d_adrs(d_adrs), .d_din(d_din),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rerr(d_rerr),
        .l_req(l_req), .l_we(l_we), .l_wst(l_wst), .l_adrs(l_adrs), .l_din(l_din),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rerr(l_rerr), .l_done(l_done),
        .rdata(rdata), .boot(boot), .mcs(mcs), .mwe(mwe), .mwst(mwst),
        .madrs(madrs), .mdin(mdin), .mdout(mdout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPRAM macro: registered read, byte-strobed write.
    logic [31:0] mem [int];
    always @(posedge clk) begin
        logic [31:0] w;
        if (mcs) begin
            w = mem.exists(int'(madrs)) ? mem[int'(madrs)] : 32'h0;
            mdout <= w;
            if (mwe) begin
                for (int b = 0; b < 4; b++)
                    if (mwst[b]) w[8*b +: 8] = mdin[8*b +: 8];
                mem[int'(madrs)] = w;
            end
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference state
    logic [31:0] shadow [int];
    bit          m_boot;
    int          m_cw, m_lw;
    logic [2:0]  p_w;
    bit          p_err, p_rd;
    logic [31:0] p_data;
    logic [2:0]  exp_w, obs_gnt, obs_rv, obs_rerr;
    logic [13:0] obs_madrs;
    logic [3:0]  obs_mwst;
    logic [31:0] obs_rdata;
    bit          obs_mcs, obs_boot;

    task automatic model_reset();
        m_boot = 1; m_cw = 0; m_lw = 0;
        p_w = 3'b000; p_err = 0; p_rd = 0; p_data = 32'h0;
    endtask

    task automatic cyc();
        logic [2:0]  w;
        logic        we;
        logic [3:0]  wst;
        logic [31:0] adrs, din, cur;
        bit          ok;
        int          key;
        @(negedge clk);
        w = 3'b000;
        if (rstn) begin
            if (m_boot) begin
                if (l_req) w = 3'b100;
            end
            else if (c_req && m_cw >= MAXWAIT) w = 3'b001;
            else if (l_req && m_lw >= MAXWAIT) w = 3'b100;
            else if (d_req) w = 3'b010;
            else if (c_req) w = 3'b001;
            else if (l_req) w = 3'b100;
        end
        exp_w = w;
        we = 0; wst = 0; adrs = 0; din = 0;
        if (w[0]) adrs = c_adrs;
        if (w[1]) begin we = d_we; wst = d_wst; adrs = d_adrs; din = d_din; end
        if (w[2]) begin we = l_we; wst = l_wst; adrs = l_adrs; din = l_din; end
        ok = (w != 0) && (adrs < 32'h0001_0000);
        obs_gnt = {l_gnt, d_gnt, c_gnt}; obs_mcs = mcs; obs_madrs = madrs; obs_mwst = mwst;
        obs_rv = {l_rvalid, d_rvalid, c_rvalid}; obs_rerr = {l_rerr, d_rerr, c_rerr};
        obs_rdata = rdata; obs_boot = boot;
        chk("gnt", 32'(obs_gnt), 32'(w));
        chk("mcs", 32'(mcs), 32'(ok));
        if (ok) begin
            chk("mwe", 32'(mwe), 32'(we));
            chk("mwst", 32'(mwst), we ? 32'(wst) : 32'h0);
            chk("madrs", 32'(madrs), 32'(adrs[15:2]));
            if (we) chk("mdin", mdin, din);
        end else begin
            chk("mwe_idle", 32'(mwe), 32'h0);
            chk("mwst_idle", 32'(mwst), 32'h0);
        end
        chk("rvalid", 32'(obs_rv), 32'(p_w));
        chk("rerr", 32'(obs_rerr), p_err ? 32'(p_w) : 32'h0);
        if (p_rd) chk("rdata", rdata, p_data);
        chk("boot", 32'(boot), 32'(m_boot));
        @(posedge clk);
        if (!rstn) model_reset();
        else begin
            key = int'(adrs[15:2]);
            cur = shadow.exists(key) ? shadow[key] : 32'h0;
            p_w = w; p_err = (w != 0) && !ok; p_rd = ok && !we; p_data = cur;
            if (ok && we) begin
                for (int b = 0; b < 4; b++)
                    if (wst[b]) cur[8*b +: 8] = din[8*b +: 8];
                shadow[key] = cur;
            end
            m_cw = (!m_boot && c_req && !w[0]) ? ((m_cw + 1 > MAXWAIT) ? MAXWAIT : m_cw + 1) : 0;
            m_lw = (l_req && !w[2]) ? ((m_lw + 1 > MAXWAIT) ? MAXWAIT : m_lw + 1) : 0;
            if (m_boot && l_done) m_boot = 0;
        end
        #1;
    endtask

    function automatic logic [31:0] radr();
        if ($urandom_range(7) == 0)
            return {16'($urandom_range(65535, 1)), 16'($urandom)};
        return {26'h0, 4'($urandom_range(15)), 2'($urandom_range(3))};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int first_c;
        bit d_denied;
        rstn = 0; l_done = 0;
        c_req = 0; c_adrs = 0;
        d_req = 0; d_we = 0; d_wst = 0; d_adrs = 0; d_din = 0;
        l_req = 1; l_we = 1; l_wst = 4'hF; l_adrs = 0; l_din = 0;
        model_reset();
        repeat (2) cyc();
        l_req = 0;
        rstn = 1;

        // Boot: L writes while C waits, then l_done releases C.
        l_req = 1; l_we = 1; l_wst = 4'hF; l_adrs = 32'h10; l_din = 32'hDEADBEEF;
        c_req = 1; c_adrs = 32'h10;
        cyc();
        chk("boot_lgnt", 32'(obs_gnt), 32'h4);
        chk("boot_madrs", 32'(obs_madrs), 32'h4);
        l_req = 0; l_done = 1;
        cyc();
        chk("boot_cgnt", 32'(obs_gnt[0]), 32'h0);
        l_done = 0;
        cyc();
        chk("run_boot", 32'(obs_boot), 32'h0);
        chk("run_cgnt", 32'(obs_gnt), 32'h1);
        c_req = 0;
        cyc();
        chk("boot_rvalid", 32'(obs_rv), 32'h1);
        chk("boot_rdata", obs_rdata, 32'hDEADBEEF);

        // Priority D > C > L
        c_req = 1; c_adrs = 32'h4;
        d_req = 1; d_we = 0; d_adrs = 32'h8;
        l_req = 1; l_we = 0; l_adrs = 32'hC;
        cyc();
        chk("prio_d", 32'(obs_gnt), 32'h2);
        d_req = 0;
        cyc();
        chk("prio_c", 32'(obs_gnt), 32'h1);
        c_req = 0;
        cyc();
        chk("prio_l", 32'(obs_gnt), 32'h4);
        l_req = 0;
        cyc();

        // Byte strobe write then readback
        d_req = 1; d_we = 1; d_wst = 4'h2; d_adrs = 32'h20; d_din = 32'h11223344;
        cyc();
        chk("strobe_mwst", 32'(obs_mwst), 32'h2);
        d_we = 0; d_wst = 0;
        cyc();
        d_req = 0;
        cyc();
        chk("strobe_rdata", obs_rdata, 32'h00003300);

        // Out-of-range access
        d_req = 1; d_we = 0; d_adrs = 32'h0001_0000;
        cyc();
        chk("rng_gnt", 32'(obs_gnt), 32'h2);
        chk("rng_mcs", 32'(obs_mcs), 32'h0);
        d_req = 0;
        cyc();
        chk("rng_rvalid", 32'(obs_rv), 32'h2);
        chk("rng_rerr", 32'(obs_rerr), 32'h2);

        // Starvation: C under continuous D traffic
        d_req = 1; d_we = 0; d_adrs = 32'h0;
        c_req = 1; c_adrs = 32'h10;
        first_c = 0; d_denied = 0;
        for (int i = 1; i <= 12 && first_c == 0; i++) begin
            cyc();
            if (obs_gnt[0]) begin
                first_c = i; d_denied = !obs_gnt[1]; c_req = 0;
            end
        end
        chk("starve_cycle", 32'(first_c), 32'(MAXWAIT + 1));
        chk("starve_d_denied", 32'(d_denied), 32'h1);
        d_req = 0;
        cyc();

        // Random traffic against the reference
        for (int n = 0; n < 600; n++) begin
            if (!c_req || exp_w[0]) begin
                c_req = ($urandom_range(2) != 0);
                c_adrs = radr();
            end
            if (!d_req || exp_w[1]) begin
                d_req = ($urandom_range(2) != 0);
                d_we = 1'($urandom); d_wst = 4'($urandom); d_adrs = radr(); d_din = $urandom;
            end
            if (!l_req || exp_w[2]) begin
                l_req = ($urandom_range(3) == 0);
                l_we = 1'($urandom); l_wst = 4'($urandom); l_adrs = radr(); l_din = $urandom;
            end
            l_done = ($urandom_range(19) == 0);
            cyc();
        end
        c_req = 0; d_req = 0; l_req = 0; l_done = 0;
        cyc();

        // Reset in the response cycle of a C read
        c_req = 1; c_adrs = 32'h10;
        cyc();
        chk("rst_cgnt", 32'(obs_gnt), 32'h1);
        c_req = 0;
        rstn = 0;
        #1;
        chk("rst_rvalid", 32'(c_rvalid), 32'h0);
        chk("rst_boot", 32'(boot), 32'h1);
        model_reset();
        cyc();
        rstn = 1;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
